// File: rtl/ariane_pkg.sv
// ============================================================================
//  Module      : ariane_pkg
//  Description : Shared types for the frontend predictor interfaces. Holds the
//                BHT update record and the default depth of the queue that
//                buffers resolved branches until they commit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ariane_pkg;

    // Width of the program counter carried in predictor update records.
    localparam int unsigned BHT_PC_WIDTH = 64;

    // Default number of resolved-but-uncommitted branches held for training.
    localparam int unsigned BHT_UPDATE_QUEUE_DEPTH = 4;

    // One training event for the branch history table.
    typedef struct packed {
        logic                    valid;
        logic [BHT_PC_WIDTH-1:0] pc;
        logic                    taken;
    } bht_update_t;

endpackage : ariane_pkg

`default_nettype wire

// File: rtl/bht_update_queue.sv
// ============================================================================
//  Module      : bht_update_queue
//  Description : In-order buffer of speculatively resolved conditional
//                branches. Entries train the BHT only once they commit; a
//                flush discards everything still uncommitted so wrong-path
//                branches never reach the predictor.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bht_update_queue
    import ariane_pkg::*;
#(
    parameter int unsigned DEPTH    = BHT_UPDATE_QUEUE_DEPTH,
    parameter int unsigned PC_WIDTH = BHT_PC_WIDTH
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       debug_mode_i,
    input  logic                       resolve_valid_i,
    input  logic [PC_WIDTH-1:0]        resolve_pc_i,
    input  logic                       resolve_taken_i,
    output logic                       resolve_ready_o,
    input  logic                       commit_i,
    output bht_update_t                bht_update_o,
    output logic [$clog2(DEPTH):0]     pending_cnt_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

    // Entry storage; validity is implied by the occupancy count, so the
    // payload itself needs no reset.
    logic [PC_WIDTH-1:0] pc_q    [DEPTH];
    logic                taken_q [DEPTH];

    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    bht_update_t      update_q, update_d;

    logic w_push;
    logic w_pop;

    // Ready looks only at the registered count so commit_i never reaches it.
    assign resolve_ready_o = (cnt_q < C_DEPTH);
    assign w_push          = resolve_valid_i && resolve_ready_o && !flush_i;
    // A commit is honoured even in a flush cycle: that branch has retired.
    assign w_pop           = commit_i && (cnt_q != '0);

    assign bht_update_o    = update_q;
    assign pending_cnt_o   = cnt_q;

    // Next-state for pointers, occupancy and the outgoing update record.
    always_comb begin
        wptr_d         = wptr_q;
        rptr_d         = rptr_q;
        cnt_d          = cnt_q;
        update_d       = update_q;
        update_d.valid = 1'b0;

        // Only a real training event refreshes pc/taken; otherwise they hold.
        if (w_pop && !debug_mode_i) begin
            update_d.valid = 1'b1;
            update_d.pc    = pc_q[rptr_q];
            update_d.taken = taken_q[rptr_q];
        end

        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (w_push) begin
                wptr_d = wptr_q + PTR_W'(1);
            end
            if (w_pop) begin
                rptr_d = rptr_q + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            cnt_q    <= '0;
            update_q <= '0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            cnt_q    <= cnt_d;
            update_q <= update_d;
        end
    end

    // Payload write at the tail on an accepted resolve.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            pc_q[wptr_q]    <= resolve_pc_i;
            taken_q[wptr_q] <= resolve_taken_i;
        end
    end

`ifndef SYNTHESIS
    // Sanity checks on the producer/consumer handshake.
    always @(posedge clk_i) begin
        if (rst_ni) begin
            if (commit_i && (cnt_q == '0) && !flush_i) begin
                $warning("bht_update_queue: commit with empty queue ignored");
            end
            if (cnt_q > C_DEPTH) begin
                $error("bht_update_queue: occupancy %0d exceeds depth %0d", cnt_q, DEPTH);
            end
        end
    end
`endif

endmodule : bht_update_queue

`default_nettype wire

// File: tb/tb_bht_update_queue.sv
// ============================================================================
//  Module      : tb_bht_update_queue
//  Description : Directed self-checking bench for bht_update_queue.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bht_update_queue;
    import ariane_pkg::*;

    logic        clk_i;
    logic        rst_ni;
    logic        flush_i;
    logic        debug_mode_i;
    logic        resolve_valid_i;
    logic [63:0] resolve_pc_i;
    logic        resolve_taken_i;
    logic        resolve_ready_o;
    logic        commit_i;
    bht_update_t bht_update_o;
    logic [2:0]  pending_cnt_o;

    int checks   = 0;
    int failures = 0;

    bht_update_queue #(.DEPTH(4), .PC_WIDTH(64)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .flush_i         (flush_i),
        .debug_mode_i    (debug_mode_i),
        .resolve_valid_i (resolve_valid_i),
        .resolve_pc_i    (resolve_pc_i),
        .resolve_taken_i (resolve_taken_i),
        .resolve_ready_o (resolve_ready_o),
        .commit_i        (commit_i),
        .bht_update_o    (bht_update_o),
        .pending_cnt_o   (pending_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Advance one clock; outputs are examined 1ns after the active edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_upd(input string tag, input logic v, input logic [63:0] pc, input logic t);
        chk({tag, ".valid"}, {63'd0, bht_update_o.valid}, {63'd0, v});
        chk({tag, ".pc"},    bht_update_o.pc, pc);
        chk({tag, ".taken"}, {63'd0, bht_update_o.taken}, {63'd0, t});
    endtask

    task automatic resolve(input logic [63:0] pc, input logic t);
        resolve_valid_i = 1'b1;
        resolve_pc_i    = pc;
        resolve_taken_i = t;
        tick();
        resolve_valid_i = 1'b0;
    endtask

    initial begin
        rst_ni          = 1'b0;
        flush_i         = 1'b0;
        debug_mode_i    = 1'b0;
        resolve_valid_i = 1'b0;
        resolve_pc_i    = '0;
        resolve_taken_i = 1'b0;
        commit_i        = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst.ready", {63'd0, resolve_ready_o}, 64'd1);
        chk("rst.cnt",   {61'd0, pending_cnt_o}, 64'd0);
        chk_upd("rst.upd", 1'b0, 64'd0, 1'b0);
        rst_ni = 1'b1;
        tick();

        // Single branch: resolve, idle cycle, commit
        resolve(64'h8000_0010, 1'b1);
        chk("t1.cnt_after_resolve", {61'd0, pending_cnt_o}, 64'd1);
        tick();
        chk("t1.cnt_hold", {61'd0, pending_cnt_o}, 64'd1);
        chk("t1.no_early_valid", {63'd0, bht_update_o.valid}, 64'd0);
        commit_i = 1'b1;
        tick();
        commit_i = 1'b0;
        chk_upd("t1.upd", 1'b1, 64'h8000_0010, 1'b1);
        chk("t1.cnt_after_commit", {61'd0, pending_cnt_o}, 64'd0);
        tick();
        chk_upd("t1.pulse_end", 1'b0, 64'h8000_0010, 1'b1);

        // Fill to capacity
        resolve(64'h100, 1'b1);
        resolve(64'h104, 1'b0);
        resolve(64'h108, 1'b1);
        chk("t2.ready_at3", {63'd0, resolve_ready_o}, 64'd1);
        resolve(64'h10C, 1'b0);
        chk("t2.cnt_full", {61'd0, pending_cnt_o}, 64'd4);
        chk("t2.ready_full", {63'd0, resolve_ready_o}, 64'd0);
        // Fifth resolve is held, not written
        resolve_valid_i = 1'b1;
        resolve_pc_i    = 64'h999;
        resolve_taken_i = 1'b1;
        tick();
        chk("t2.cnt_held", {61'd0, pending_cnt_o}, 64'd4);
        // Full queue: commit and resolve together; only the pop happens
        commit_i = 1'b1;
        tick();
        resolve_valid_i = 1'b0;
        chk_upd("t3.upd0", 1'b1, 64'h100, 1'b1);
        chk("t3.cnt", {61'd0, pending_cnt_o}, 64'd3);
        chk("t3.ready", {63'd0, resolve_ready_o}, 64'd1);
        tick();
        chk_upd("t2.upd1", 1'b1, 64'h104, 1'b0);
        tick();
        chk_upd("t2.upd2", 1'b1, 64'h108, 1'b1);
        tick();
        commit_i = 1'b0;
        chk_upd("t2.upd3", 1'b1, 64'h10C, 1'b0);
        chk("t2.cnt_empty", {61'd0, pending_cnt_o}, 64'd0);

        // Flush together with commit and a resolve
        resolve(64'h300, 1'b1);
        resolve(64'h304, 1'b0);
        resolve(64'h308, 1'b1);
        chk("t4.cnt3", {61'd0, pending_cnt_o}, 64'd3);
        flush_i         = 1'b1;
        commit_i        = 1'b1;
        resolve_valid_i = 1'b1;
        resolve_pc_i    = 64'h30C;
        tick();
        flush_i         = 1'b0;
        resolve_valid_i = 1'b0;
        chk_upd("t4.head", 1'b1, 64'h300, 1'b1);
        chk("t4.cnt0", {61'd0, pending_cnt_o}, 64'd0);
        tick();
        commit_i = 1'b0;
        chk_upd("t4.empty_commit", 1'b0, 64'h300, 1'b1);

        // Debug mode drops the committed entry
        resolve(64'h200, 1'b1);
        resolve(64'h204, 1'b0);
        debug_mode_i = 1'b1;
        commit_i     = 1'b1;
        tick();
        debug_mode_i = 1'b0;
        chk_upd("t5.dropped", 1'b0, 64'h300, 1'b1);
        chk("t5.cnt1", {61'd0, pending_cnt_o}, 64'd1);
        tick();
        commit_i = 1'b0;
        chk_upd("t5.next", 1'b1, 64'h204, 1'b0);
        chk("t5.cnt0", {61'd0, pending_cnt_o}, 64'd0);

        // Interleaved resolve/commit across several pointer wraps
        for (int i = 0; i < 10; i++) begin
            resolve_valid_i = 1'b1;
            resolve_pc_i    = 64'h400 + 64'(4 * i);
            resolve_taken_i = (i % 3 == 0);
            commit_i        = (i > 0);
            tick();
            chk("t6.cnt", {61'd0, pending_cnt_o}, 64'd1);
            if (i > 0) begin
                chk_upd("t6.upd", 1'b1, 64'h400 + 64'(4 * (i - 1)), ((i - 1) % 3 == 0));
            end
        end
        resolve_valid_i = 1'b0;
        commit_i        = 1'b1;
        tick();
        commit_i = 1'b0;
        chk_upd("t6.last", 1'b1, 64'h424, 1'b1);
        chk("t6.cnt_end", {61'd0, pending_cnt_o}, 64'd0);

        // Asynchronous reset cancels a pending pulse immediately
        resolve(64'h500, 1'b0);
        resolve(64'h504, 1'b1);
        commit_i = 1'b1;
        tick();
        commit_i = 1'b0;
        chk_upd("t7.pre_rst", 1'b1, 64'h500, 1'b0);
        chk("t7.cnt_pre", {61'd0, pending_cnt_o}, 64'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("t7.valid_rst", {63'd0, bht_update_o.valid}, 64'd0);
        chk("t7.cnt_rst", {61'd0, pending_cnt_o}, 64'd0);
        chk("t7.ready_rst", {63'd0, resolve_ready_o}, 64'd1);
        tick();
        rst_ni = 1'b1;
        tick();
        commit_i = 1'b1;
        tick();
        commit_i = 1'b0;
        chk("t7.post_rst_commit", {63'd0, bht_update_o.valid}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_bht_update_queue

`default_nettype wire
